// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode map,
// controller states and source-register usage decode.
package hazard_ctrl_pkg;

  localparam int STAT_WIDTH = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic {
    HZ_RUN,
    HZ_MDU_WAIT
  } hz_state_t;

  // Returns {uses_rs2, uses_rs1}; lui/auipc/jal and unknown opcodes read nothing.
  function automatic logic [1:0] src_use(input logic [6:0] opcode);
    logic [1:0] use_bits;
    use_bits = 2'b00;
    case (opcode)
      OPC_R, OPC_STORE, OPC_BRANCH: use_bits = 2'b11;
      OPC_IMM, OPC_LOAD, OPC_JALR:  use_bits = 2'b01;
      default:                      use_bits = 2'b00;
    endcase
    return use_bits;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute boundary signals seen by the hazard controller, plus the
// stall/flush controls and statistics it returns to the pipeline.
interface hazard_ctrl_if #(
  parameter int WIDTH = hazard_ctrl_pkg::STAT_WIDTH
);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [6:0]       id_opcode;
  logic [4:0]       ex_rd;
  logic             ex_reg_wr_en;
  logic             ex_mem_to_reg;
  logic             ex_mdu_op;
  logic             mdu_done;
  logic             ex_branch_taken;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_bubble;
  logic             mdu_timeout;
  logic [WIDTH-1:0] stall_cnt;
  logic [WIDTH-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_opcode, ex_rd, ex_reg_wr_en, ex_mem_to_reg,
           ex_mdu_op, mdu_done, ex_branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_bubble, mdu_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_opcode, ex_rd, ex_reg_wr_en, ex_mem_to_reg,
           ex_mdu_op, mdu_done, ex_branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_bubble, mdu_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, MDU multi-cycle stalls with
// timeout, branch redirect flushes and saturating stall/flush statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WIDTH       = STAT_WIDTH,
  parameter int MDU_TIMEOUT = 64,
  parameter int TO_W        = $clog2(MDU_TIMEOUT + 1)
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

  hz_state_t       state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            guard_q, guard_d;

  logic [1:0] use_bits;
  logic       load_use;
  logic       pc_stall, if_id_stall, if_id_flush;
  logic       id_ex_stall, id_ex_flush, ex_mem_bubble;

  assign use_bits = src_use(hz.id_opcode);
  assign load_use = hz.ex_mem_to_reg && hz.ex_reg_wr_en && (hz.ex_rd != 5'd0) &&
                    ((use_bits[0] && (hz.ex_rd == hz.id_rs1)) ||
                     (use_bits[1] && (hz.ex_rd == hz.id_rs2)));

  // guard_q covers the cycle after an MDU release, when the finished op is still in EX.
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    timeout_d     = timeout_q;
    guard_d       = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;

    case (state_q)
      HZ_RUN: begin
        if (hz.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hz.ex_mdu_op && !hz.mdu_done && !guard_q) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          state_d       = HZ_MDU_WAIT;
          to_cnt_d      = '0;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      HZ_MDU_WAIT: begin
        if (hz.mdu_done) begin
          state_d = HZ_RUN;
          guard_d = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = HZ_RUN;
          guard_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          to_cnt_d      = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = HZ_RUN;
    endcase

    if (rst) begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      guard_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      guard_q   <= guard_d;
    end
  end

  sat_counter #(.W(WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .count (hz.flush_cnt)
  );

  assign hz.pc_stall      = pc_stall;
  assign hz.if_id_stall   = if_id_stall;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_stall   = id_ex_stall;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_bubble = ex_mem_bubble;
  assign hz.mdu_timeout   = timeout_q;

  // A pipeline register is never told to hold and clear in the same cycle.
  assert property (@(posedge clk) disable iff (rst)
    !(if_id_stall && if_id_flush) && !(id_ex_stall && id_ex_flush));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, false hazards, branch priority,
// MDU stall/release/guard, timeout, counter saturation and mid-stall reset.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int W = 4;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110010;
  localparam logic [5:0] BR   = 6'b001010;
  localparam logic [5:0] MDU  = 6'b110101;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.WIDTH(W)) hz ();

  hazard_ctrl #(.WIDTH(W), .MDU_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [6:0] opc, input logic [4:0] rd, input logic wr,
                               input logic m2r, input logic mdu, input logic done,
                               input logic br);
    @(posedge clk);
    #1;
    rst                = r;
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_opcode       = opc;
    hz.ex_rd           = rd;
    hz.ex_reg_wr_en    = wr;
    hz.ex_mem_to_reg   = m2r;
    hz.ex_mdu_op       = mdu;
    hz.mdu_done        = done;
    hz.ex_branch_taken = br;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush,
                hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_bubble};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkValue(input string tag, input logic [W-1:0] observed,
                            input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    applyStimulus(1, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
    checkOutput("reset_ctrl_mdu_pending", NONE);
    applyStimulus(1, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
    checkOutput("reset_ctrl", NONE);
    checkValue("reset_stall_cnt", hz.stall_cnt, 4'd0);
    checkValue("reset_flush_cnt", hz.flush_cnt, 4'd0);
    checkValue("reset_timeout", {3'b0, hz.mdu_timeout}, 4'd0);

    applyStimulus(0, 5, 7, OPC_R, 5, 1, 1, 0, 0, 0);
    checkOutput("load_use", LU);
    applyStimulus(0, 5, 7, OPC_R, 0, 0, 0, 0, 0, 0);
    checkOutput("bubble_in_ex", NONE);
    checkValue("stall_cnt_after_lu", hz.stall_cnt, 4'd1);

    applyStimulus(0, 0, 7, OPC_R, 0, 1, 1, 0, 0, 0);
    checkOutput("x0_load", NONE);
    applyStimulus(0, 5, 0, OPC_LUI, 5, 1, 1, 0, 0, 0);
    checkOutput("lui_no_src", NONE);
    applyStimulus(0, 1, 5, OPC_IMM, 5, 1, 1, 0, 0, 0);
    checkOutput("opimm_rs2_unused", NONE);
    applyStimulus(0, 1, 5, OPC_STORE, 5, 1, 1, 0, 0, 0);
    checkOutput("store_rs2_hazard", LU);
    applyStimulus(0, 5, 5, OPC_R, 5, 0, 1, 0, 0, 0);
    checkOutput("load_no_wr_en", NONE);

    applyStimulus(0, 5, 7, OPC_R, 5, 1, 1, 0, 0, 1);
    checkOutput("branch_over_lu", BR);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 1, 0);
    checkOutput("mdu_single_cycle", NONE);
    checkValue("stall_cnt_pre_mdu", hz.stall_cnt, 4'd2);
    checkValue("flush_cnt_branch", hz.flush_cnt, 4'd1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 0, (i == 2) ? 1'b1 : 1'b0);
      checkOutput("mdu_stall", MDU);
    end
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 1, 0);
    checkOutput("mdu_release", NONE);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
    checkOutput("mdu_guard_no_reentry", NONE);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 0, 0, 0);
    checkOutput("mdu_idle", NONE);
    checkValue("stall_cnt_after_mdu", hz.stall_cnt, 4'd7);
    checkValue("flush_cnt_after_mdu", hz.flush_cnt, 4'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
      checkOutput("timeout_stall", MDU);
    end
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
    checkOutput("timeout_release", NONE);
    checkValue("timeout_not_yet", {3'b0, hz.mdu_timeout}, 4'd0);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 0, 0, 0);
    checkOutput("timeout_idle", NONE);
    checkValue("timeout_flag", {3'b0, hz.mdu_timeout}, 4'd1);
    checkValue("stall_cnt_full", hz.stall_cnt, 4'd15);

    applyStimulus(0, 5, 7, OPC_R, 5, 1, 1, 0, 0, 0);
    checkOutput("load_use_at_sat", LU);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 0, 0, 0);
    checkValue("stall_cnt_saturated", hz.stall_cnt, 4'd15);
    checkValue("timeout_sticky", {3'b0, hz.mdu_timeout}, 4'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
      checkOutput("pre_reset_stall", MDU);
    end
    applyStimulus(1, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
    checkOutput("reset_mid_wait", NONE);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 0, 0, 0);
    checkOutput("after_reset_idle", NONE);
    checkValue("after_reset_stall_cnt", hz.stall_cnt, 4'd0);
    checkValue("after_reset_flush_cnt", hz.flush_cnt, 4'd0);
    checkValue("after_reset_timeout", {3'b0, hz.mdu_timeout}, 4'd0);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 0, 0);
    checkOutput("run_after_reset", MDU);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 1, 1, 0);
    checkOutput("release_after_reset", NONE);
    applyStimulus(0, 0, 0, OPC_R, 0, 0, 0, 0, 0, 0);
    checkValue("final_stall_cnt", hz.stall_cnt, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. Generates the stall/flush controls that the IF/ID and ID/EX pipeline registers consume.
- Sits beside the decode/execute boundary. Compares ID-stage source registers with EX-stage destination/control state.
- Sequences three cases:
  - one-cycle load-use bubbles
  - multi-cycle stalls for the iterative mul/div unit (MDU)
  - branch/jump redirect flushes
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
WIDTH, from all_pkgs (32), width of statistics counters
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before forced release and error flag
TO_W, $clog2(MDU_TIMEOUT+1), timeout counter width

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
id_rs1  input  5  ID-stage rs1 field
id_rs2  input  5  ID-stage rs2 field
id_opcode  input  7  ID-stage opcode
ex_rd  input  5  EX-stage destination register
ex_reg_wr_en  input  1  EX instruction writes rd
ex_mem_to_reg  input  1  EX instruction is a load
ex_mdu_op  input  1  EX instruction is a mul/div op
mdu_done  input  1  MDU result valid this cycle
ex_branch_taken  input  1  EX resolved taken branch/jal/jalr
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  zero IF/ID register
id_ex_stall  output  1  hold ID/EX register
id_ex_flush  output  1  zero ID/EX register (bubble)
ex_mem_bubble  output  1  insert bubble into EX/MEM while MDU busy
mdu_timeout  output  1  sticky error: MDU exceeded MDU_TIMEOUT
stall_cnt  output  WIDTH  saturating count of cycles with pc_stall=1
flush_cnt  output  WIDTH  saturating count of cycles with if_id_flush=1

Behaviour:
- Reset, while rst=1:
  - state=RUN
  - timeout counter=0
  - stall_cnt=0, flush_cnt=0
  - mdu_timeout=0
  - all control outputs forced to 0
- Source use, decoded from id_opcode:
  - R (0110011), store (0100011), branch (1100011): rs1 and rs2 used
  - OP-IMM (0010011), load (0000011), jalr (1100111): rs1 only
  - lui, auipc, jal and unknown opcodes: none
- load_use = ex_mem_to_reg & ex_reg_wr_en & ex_rd!=0 & ((use1 & ex_rd==id_rs1) | (use2 & ex_rd==id_rs2)).
- Control outputs are Mealy: combinational from state and current inputs, zero latency.
- State RUN, priority order:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, no stalls; overrides load_use and MDU entry. Stay RUN.
  2. ex_mdu_op & !mdu_done: pc_stall=1, if_id_stall=1, id_ex_stall=1, ex_mem_bubble=1. Next MDU_WAIT, timeout counter cleared.
  3. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1, id_ex_stall=0. Stay RUN; the next cycle re-evaluates with the bubble in EX.
  4. Otherwise all controls 0.
  - ex_mdu_op & mdu_done in the same cycle: no stall (single-cycle completion).
- State MDU_WAIT:
  - mdu_done=1: all controls 0 this cycle; next RUN.
  - Else if counter==MDU_TIMEOUT-1: controls 0 this cycle (forced release), mdu_timeout set (sticky until rst); next RUN.
  - Else: pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble=1; counter+1.
  - ex_branch_taken and load_use are ignored in MDU_WAIT, since EX holds the MDU op.
  - Release cycle: RUN entry does not re-check ex_mdu_op in the same cycle. A one-cycle RUN_GUARD flag suppresses re-entry on the cycle the state returns to RUN while the same op is still in EX.
- Counters:
  - stall_cnt +1 on each cycle pc_stall=1
  - flush_cnt +1 on each cycle if_id_flush=1
  - both saturate at all-ones, no wrap
- Reset mid-MDU_WAIT: next state RUN; stalls drop in the rst cycle itself.
- Invariant (assertion): a stall and a flush are never both asserted on the same register.

Decomposition:
- Add to all_pkgs:
  - opcode localparams OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC
  - enum hz_state_t {HZ_RUN, HZ_MDU_WAIT}
- One natural sub-module: sat_counter (parameter W; inc input; saturating count output), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: EX lw x5 (ex_rd=5, mem_to_reg=1, wr_en=1), ID add x6,x5,x7 → one cycle with pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle with the bubble (ex_rd=0) → all 0; stall_cnt=1.
- False hazards: ex_rd=0 load with id_rs1=0; and ex_rd=5 load with ID lui x5 → no stall.
- Branch vs load-use: ex_branch_taken=1 together with load_use → if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1.
- MDU: ex_mdu_op=1, mdu_done at cycle 5 → stalls asserted cycles 0-4, released cycle 5; stall_cnt=5; no re-entry on the following cycle.
- Timeout: MDU_TIMEOUT=8, mdu_done never asserted → stalls for 8 cycles, release, mdu_timeout=1 held until rst.
- Reset mid-MDU_WAIT at cycle 3 → outputs 0 in the rst cycle; counters 0; state RUN afterwards.
